// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM encoding, default word width and mode helpers.
package spi_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    ACTIVE    = 2'd2
  } spi_state_e;

  // Data is sampled on the leading sclk edge when CPHA = 0.
  function automatic logic sample_on_leading(input logic cpha);
    return ~cpha;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for one asynchronous pin, with a third stage for edge detection.
module spi_sync_edge #(
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise_c,
  output logic fall_c
);

  logic [2:0] sync_q;
  logic [2:0] sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], d};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {3{RESET_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q      = sync_q[1];
  assign rise_c = sync_q[1] & ~sync_q[2];
  assign fall_c = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_slave.sv
// Byte-oriented SPI slave oversampled in clk: receives MSB-first words on mosi,
// returns tx_data on miso, and strobes rx_done/tx_done at each word boundary.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter bit          CPOL       = 1'b0,
  parameter bit          CPHA       = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sclk,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_done,
  output logic                  tx_done,
  output logic                  busy
);

  localparam int unsigned CNT_W       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam bit          SAMPLE_LEAD = sample_on_leading(CPHA);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic sclk_level_unused, mosi_rise_unused, mosi_fall_unused;
  logic sclk_rise, sclk_fall, cs_s, cs_rise, cs_fall, mosi_s;
  logic lead_ev, trail_ev, sample_ev, shift_ev;

  spi_state_e                state_q, state_d;
  logic [CNT_W-1:0]          bit_cnt_q, bit_cnt_d;
  logic [1:0]                settle_cnt_q, settle_cnt_d;
  logic [DATA_WIDTH-2:0]     rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0]     tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0]     rx_data_q, rx_data_d;
  logic                      miso_q, miso_d, miso_oe_q, miso_oe_d;
  logic                      rx_done_q, rx_done_d, tx_done_q, tx_done_d;
  logic                      busy_q, busy_d;

  spi_sync_edge #(.RESET_VAL(CPOL)) u_sync_sclk (
    .clk(clk), .reset(reset), .d(sclk),
    .q(sclk_level_unused), .rise_c(sclk_rise), .fall_c(sclk_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .reset(reset), .d(cs),
    .q(cs_s), .rise_c(cs_rise), .fall_c(cs_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .d(mosi),
    .q(mosi_s), .rise_c(mosi_rise_unused), .fall_c(mosi_fall_unused)
  );

  assign lead_ev   = CPOL ? sclk_fall : sclk_rise;
  assign trail_ev  = CPOL ? sclk_rise : sclk_fall;
  assign sample_ev = SAMPLE_LEAD ? lead_ev : trail_ev;
  assign shift_ev  = SAMPLE_LEAD ? trail_ev : lead_ev;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= WAIT_IDLE;
      bit_cnt_q    <= '0;
      settle_cnt_q <= '0;
      rx_shift_q   <= '0;
      tx_shift_q   <= '0;
      rx_data_q    <= '0;
      miso_q       <= 1'b0;
      miso_oe_q    <= 1'b0;
      rx_done_q    <= 1'b0;
      tx_done_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      rx_shift_q   <= rx_shift_d;
      tx_shift_q   <= tx_shift_d;
      rx_data_q    <= rx_data_d;
      miso_q       <= miso_d;
      miso_oe_q    <= miso_oe_d;
      rx_done_q    <= rx_done_d;
      tx_done_q    <= tx_done_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    settle_cnt_d = settle_cnt_q;
    rx_shift_d   = rx_shift_q;
    tx_shift_d   = tx_shift_q;
    rx_data_d    = rx_data_q;
    miso_d       = miso_q;
    miso_oe_d    = miso_oe_q;
    rx_done_d    = 1'b0;
    tx_done_d    = 1'b0;

    unique case (state_q)
      // Synchronizers still hold reset values for two cycles; only trust cs afterwards.
      WAIT_IDLE: begin
        if (settle_cnt_q != 2'd2) begin
          settle_cnt_d = settle_cnt_q + 2'd1;
        end else if (cs_s) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (cs_fall) begin
          tx_shift_d = tx_data;
          bit_cnt_d  = '0;
          tx_done_d  = 1'b1;
          miso_oe_d  = 1'b1;
          state_d    = ACTIVE;
          if (!CPHA) begin
            miso_d = tx_data[DATA_WIDTH-1];
          end
        end
      end
      ACTIVE: begin
        // With CPHA = 0 the MSB is already out, so a shift edge at bit_cnt 0 is the stale one.
        if (shift_ev && (CPHA || (bit_cnt_q != '0))) begin
          miso_d     = CPHA ? tx_shift_q[DATA_WIDTH-1] : tx_shift_q[DATA_WIDTH-2];
          tx_shift_d = tx_shift_q << 1;
        end
        if (sample_ev) begin
          rx_shift_d = {rx_shift_q[DATA_WIDTH-3:0], mosi_s};
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d  = '0;
            rx_data_d  = {rx_shift_q, mosi_s};
            rx_done_d  = 1'b1;
            tx_shift_d = tx_data;
            tx_done_d  = 1'b1;
            if (!CPHA) begin
              miso_d = tx_data[DATA_WIDTH-1];
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
        if (cs_rise) begin
          state_d   = IDLE;
          miso_oe_d = 1'b0;
          miso_d    = 1'b0;
        end
      end
      default: state_d = WAIT_IDLE;
    endcase

    busy_d = (state_d == ACTIVE);
  end

  assign miso    = miso_q;
  assign miso_oe = miso_oe_q;
  assign rx_data = rx_data_q;
  assign rx_done = rx_done_q;
  assign tx_done = tx_done_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: one instance per SPI mode, driven by a behavioural SPI master.
module tb_spi_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [3:0] sclk_v, cs_v, mosi_v, miso_v, miso_oe_v, rx_done_v, tx_done_v, busy_v;
  logic [7:0] tx_data_v [4];
  logic [7:0] rx_data_v [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave #(.DATA_WIDTH(8), .CPOL(1'(g / 2)), .CPHA(1'(g % 2))) u_dut (
      .clk(clk), .reset(reset), .sclk(sclk_v[g]), .cs(cs_v[g]), .mosi(mosi_v[g]),
      .miso(miso_v[g]), .miso_oe(miso_oe_v[g]), .tx_data(tx_data_v[g]),
      .rx_data(rx_data_v[g]), .rx_done(rx_done_v[g]), .tx_done(tx_done_v[g]),
      .busy(busy_v[g])
    );
  end

  int tests = 0;
  int fails = 0;
  int rx_cnt [4];
  int tx_solo_cnt [4];
  int tx_pair_cnt [4];
  logic [7:0] rx_q [$];
  logic [7:0] m_tx [16];
  logic [7:0] m_rx [16];
  logic       busy_end, snap_busy, snap_oe;
  logic [7:0] snap_rx;

  typedef struct {
    int         mode;
    logic [7:0] m_word;
    logic [7:0] s_word;
  } vec_t;
  vec_t vecs [8];

  // Done-strobe monitor, sampled away from the active edge.
  always @(negedge clk) begin
    for (int g = 0; g < 4; g++) begin
      if (rx_done_v[g]) begin
        rx_cnt[g]++;
        rx_q.push_back(rx_data_v[g]);
      end
      if (tx_done_v[g] && rx_done_v[g]) tx_pair_cnt[g]++;
      if (tx_done_v[g] && !rx_done_v[g]) tx_solo_cnt[g]++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] q_at(input int i);
    if (i < rx_q.size()) return 32'(rx_q[i]);
    return 'x;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Behavioural master: nbits MSB-first bits across m_tx words, captures miso into m_rx.
  task automatic xfer(input int k, input int half, input int nbits, input int rst_after);
    bit cpol, cpha;
    int w, pos;
    cpol = (k / 2) != 0;
    cpha = (k % 2) != 0;
    for (int i = 0; i < 16; i++) m_rx[i] = 8'h00;
    cs_v[k] = 1'b0;
    if (!cpha) mosi_v[k] = m_tx[0][7];
    wait_clk(half);
    for (int b = 0; b < nbits; b++) begin
      w = b / 8;
      pos = 7 - (b % 8);
      sclk_v[k] = ~cpol;
      if (cpha) mosi_v[k] = m_tx[w][pos];
      else m_rx[w][pos] = miso_v[k];
      wait_clk(half);
      sclk_v[k] = cpol;
      if (cpha) m_rx[w][pos] = miso_v[k];
      else if (b + 1 < nbits) mosi_v[k] = m_tx[(b + 1) / 8][7 - ((b + 1) % 8)];
      wait_clk(half);
      if (b == rst_after) begin
        reset = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        snap_busy = busy_v[k];
        snap_oe   = miso_oe_v[k];
        snap_rx   = rx_data_v[k];
      end
    end
    busy_end = busy_v[k];
    cs_v[k] = 1'b1;
    mosi_v[k] = 1'b0;
  endtask

  task automatic run_word(input int k, input logic [7:0] mw, input logic [7:0] sw, input string tag);
    int rx0, ts0, tp0;
    tx_data_v[k] = sw;
    m_tx[0] = mw;
    rx0 = rx_cnt[k];
    ts0 = tx_solo_cnt[k];
    tp0 = tx_pair_cnt[k];
    rx_q.delete();
    xfer(k, 4, 8, -1);
    wait_clk(6);
    check({tag, "_rx_cnt"}, 32'(rx_cnt[k] - rx0), 1);
    check({tag, "_rx_word"}, q_at(0), 32'(mw));
    check({tag, "_rx_data"}, 32'(rx_data_v[k]), 32'(mw));
    check({tag, "_master_rx"}, 32'(m_rx[0]), 32'(sw));
    check({tag, "_tx_done_csfall"}, 32'(tx_solo_cnt[k] - ts0), 1);
    check({tag, "_tx_done_with_rx"}, 32'(tx_pair_cnt[k] - tp0), 1);
    check({tag, "_busy_in_frame"}, 32'(busy_end), 1);
    check({tag, "_busy_after"}, 32'(busy_v[k]), 0);
    check({tag, "_oe_after"}, 32'(miso_oe_v[k]), 0);
  endtask

  initial begin
    int rx0, ts0, tp0, n, stress_rx;
    logic wait_ok;
    reset = 1'b1;
    sclk_v = 4'b1100;
    cs_v = 4'hF;
    mosi_v = 4'h0;
    for (int g = 0; g < 4; g++) begin
      tx_data_v[g] = 8'h00;
      rx_cnt[g] = 0;
      tx_solo_cnt[g] = 0;
      tx_pair_cnt[g] = 0;
    end
    @(posedge clk);
    #2;
    wait_clk(2);
    for (int g = 0; g < 4; g++) begin
      check($sformatf("reset_rx_data%0d", g), 32'(rx_data_v[g]), 0);
      check($sformatf("reset_miso%0d", g), 32'(miso_v[g]), 0);
      check($sformatf("reset_oe%0d", g), 32'(miso_oe_v[g]), 0);
      check($sformatf("reset_busy%0d", g), 32'(busy_v[g]), 0);
    end
    reset = 1'b0;
    wait_clk(6);

    // Table: random words over all modes, then the fixed mode sweep ending on mode 0.
    for (int i = 0; i < 4; i++) begin
      vecs[i].mode = i;
      vecs[i].m_word = 8'($urandom);
      vecs[i].s_word = 8'($urandom);
    end
    vecs[4] = '{1, 8'hC3, 8'h69};
    vecs[5] = '{2, 8'hC3, 8'h69};
    vecs[6] = '{3, 8'hC3, 8'h69};
    vecs[7] = '{0, 8'h3C, 8'hAD};
    for (int i = 0; i < 8; i++) begin
      run_word(vecs[i].mode, vecs[i].m_word, vecs[i].s_word, $sformatf("vec%0d_m%0d", i, vecs[i].mode));
    end

    // Abort after 5 sample edges: partial word dropped, rx_data keeps 0x3C.
    m_tx[0] = 8'hFF;
    rx0 = rx_cnt[0];
    xfer(0, 4, 5, -1);
    wait_clk(3);
    check("abort_oe_3clk", 32'(miso_oe_v[0]), 0);
    wait_clk(6);
    check("abort_rx_cnt", 32'(rx_cnt[0] - rx0), 0);
    check("abort_rx_data", 32'(rx_data_v[0]), 32'h3C);
    check("abort_busy", 32'(busy_v[0]), 0);
    run_word(0, 8'h81, 8'hAD, "post_abort");

    // Back-to-back words; slave tx_data swapped after the cs-fall tx_done.
    tx_data_v[0] = 8'hAD;
    m_tx[0] = 8'h12;
    m_tx[1] = 8'h34;
    rx0 = rx_cnt[0];
    ts0 = tx_solo_cnt[0];
    tp0 = tx_pair_cnt[0];
    rx_q.delete();
    n = 0;
    fork
      xfer(0, 4, 16, -1);
      begin
        while (tx_solo_cnt[0] == ts0 && n < 40) begin
          @(posedge clk);
          n++;
        end
        #2;
        tx_data_v[0] = 8'h5A;
      end
    join
    wait_ok = (n < 40);
    wait_clk(6);
    check("b2b_txdone_wait", 32'(wait_ok), 1);
    check("b2b_rx_cnt", 32'(rx_cnt[0] - rx0), 2);
    check("b2b_rx_word0", q_at(0), 32'h12);
    check("b2b_rx_word1", q_at(1), 32'h34);
    check("b2b_master_rx0", 32'(m_rx[0]), 32'hAD);
    check("b2b_master_rx1", 32'(m_rx[1]), 32'h5A);
    check("b2b_tx_done_with_rx", 32'(tx_pair_cnt[0] - tp0), 2);

    // Reset pulsed mid-frame with cs low: the rest of the frame must be ignored.
    tx_data_v[0] = 8'h66;
    m_tx[0] = 8'hF0;
    rx0 = rx_cnt[0];
    xfer(0, 4, 8, 3);
    wait_clk(6);
    check("midrst_rx_data", 32'(snap_rx), 0);
    check("midrst_oe", 32'(snap_oe), 0);
    check("midrst_busy", 32'(snap_busy), 0);
    check("midrst_busy_end", 32'(busy_end), 0);
    check("midrst_rx_cnt", 32'(rx_cnt[0] - rx0), 0);
    run_word(0, 8'hA5, 8'h3C, "post_reset");

    // Ratio stress at clk:sclk = 4:1, ten frames of ten back-to-back random words.
    stress_rx = 0;
    for (int f = 0; f < 10; f++) begin
      for (int w = 0; w < 10; w++) m_tx[w] = 8'($urandom);
      rx0 = rx_cnt[0];
      rx_q.delete();
      xfer(0, 2, 80, -1);
      wait_clk(6);
      stress_rx += rx_cnt[0] - rx0;
      for (int w = 0; w < 10; w++) begin
        check($sformatf("stress_f%0d_w%0d", f, w), q_at(w), 32'(m_tx[w]));
      end
    end
    check("stress_rx_total", 32'(stress_rx), 100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests);
    $fatal(1, "timeout");
  end

endmodule
